// File: rtl/bf_pkg.sv
// Shared definitions for the fusion systolic array: default widths, legal
// precision codes, controller state encoding and precision legalisation.
package bf_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int PSUM_W_DEF = 32;
  localparam int CFG_W_W    = 4;

  localparam logic [CFG_W_W-1:0] WIDTH_1 = 4'd1;
  localparam logic [CFG_W_W-1:0] WIDTH_2 = 4'd2;
  localparam logic [CFG_W_W-1:0] WIDTH_4 = 4'd4;
  localparam logic [CFG_W_W-1:0] WIDTH_8 = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Precision/sign configuration that every vector in flight shares.
  typedef struct packed {
    logic [CFG_W_W-1:0] in_w;
    logic [CFG_W_W-1:0] wt_w;
    logic               s_in;
    logic               s_wt;
  } cfg_t;

  function automatic logic width_legal(input logic [CFG_W_W-1:0] w);
    return (w == WIDTH_1) || (w == WIDTH_2) || (w == WIDTH_4) || (w == WIDTH_8);
  endfunction

  // Unsupported precision codes fall back to full 8-bit operands.
  function automatic logic [CFG_W_W-1:0] legalise_width(input logic [CFG_W_W-1:0] w);
    return width_legal(w) ? w : WIDTH_8;
  endfunction

endpackage

// File: rtl/fusion_unit.sv
// Combinational precision-configurable multiplier: keeps the low `width` bits of
// each operand, optionally sign-extends them, and returns a PSUM_W product.
module fusion_unit
  import bf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PSUM_W = PSUM_W_DEF
) (
  input  logic [DATA_W-1:0]  a_i,
  input  logic [DATA_W-1:0]  b_i,
  input  logic [CFG_W_W-1:0] a_width_i,
  input  logic [CFG_W_W-1:0] b_width_i,
  input  logic               a_signed_i,
  input  logic               b_signed_i,
  output logic [PSUM_W-1:0]  prod_o
);

  localparam int PW = 2 * DATA_W + 2;

  // One extra bit so unsigned full-width operands stay positive.
  function automatic logic [DATA_W:0] op_ext(input logic [DATA_W-1:0] x,
                                             input logic [CFG_W_W-1:0] w,
                                             input logic s);
    logic            msb;
    logic [DATA_W:0] r;
    msb = 1'b0;
    r   = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == int'(w) - 1) msb = x[i];
    end
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = (i < int'(w)) ? x[i] : (s & msb);
    end
    r[DATA_W] = s & msb;
    return r;
  endfunction

  logic [DATA_W:0]      a_x;
  logic [DATA_W:0]      b_x;
  logic signed [PW-1:0] a_s;
  logic signed [PW-1:0] b_s;
  logic signed [PW-1:0] p;

  assign a_x    = op_ext(a_i, a_width_i, a_signed_i);
  assign b_x    = op_ext(b_i, b_width_i, b_signed_i);
  assign a_s    = {{(PW-DATA_W-1){a_x[DATA_W]}}, a_x};
  assign b_s    = {{(PW-DATA_W-1){b_x[DATA_W]}}, b_x};
  assign p      = a_s * b_s;
  assign prod_o = {{(PSUM_W-PW){p[PW-1]}}, p};

endmodule

// File: rtl/fusion_systolic_array.sv
// Weight-stationary ROWSxCOLS systolic array: inputs are skewed per row, psums
// ripple down one row per cycle and leave through a final output register.
module fusion_systolic_array
  import bf_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int DATA_W = DATA_W_DEF,
  parameter int PSUM_W = PSUM_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CFG_W_W-1:0]         in_width,
  input  logic [CFG_W_W-1:0]         weight_width,
  input  logic                       s_in,
  input  logic                       s_weight,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [$clog2(ROWS)-1:0]    w_row,
  input  logic [COLS*DATA_W-1:0]     w_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_W-1:0]     inputs,
  output logic                       out_valid,
  output logic [COLS*PSUM_W-1:0]     psums,
  output logic                       busy,
  output logic                       cfg_err
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // ready never depends on valid, and out_valid is a one-cycle pulse.
  state_e state_q, state_d;
  cfg_t   cfg_in, cfg_q;
  logic   cfg_err_q;
  logic   cfg_bad, cfg_diff, pending, accept, wr;

  logic [ROWS:0]              vld_q;
  logic                       out_valid_q;
  logic [COLS*PSUM_W-1:0]     psums_q;
  logic [DATA_W-1:0]          wgt_q  [ROWS][COLS];
  logic [DATA_W-1:0]          x_row  [ROWS];
  logic [PSUM_W-1:0]          prod   [ROWS][COLS];
  logic [PSUM_W-1:0]          psum_q [ROWS][COLS];
  logic [PSUM_W-1:0]          psum_d [ROWS][COLS];

  assign cfg_in   = {legalise_width(in_width), legalise_width(weight_width), s_in, s_weight};
  assign cfg_bad  = !width_legal(in_width) || !width_legal(weight_width);
  assign cfg_diff = (cfg_in != cfg_q);
  assign pending  = w_valid || (in_valid && cfg_diff);
  assign accept   = in_valid && in_ready;
  assign wr       = w_valid && w_ready;
  assign busy     = |vld_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_RUN;
      ST_RUN: begin
        if (pending)              state_d = ST_DRAIN;
        else if (!busy && !accept) state_d = ST_IDLE;
      end
      ST_DRAIN: if (!busy) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Weight writes win over vectors in IDLE; RUN only accepts same-config vectors.
  always_comb begin
    in_ready = 1'b0;
    w_ready  = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          w_ready  = 1'b1;
          in_ready = !w_valid;
        end
        ST_RUN:  in_ready = !w_valid && !cfg_diff;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      if (accept && state_q == ST_IDLE) cfg_q <= cfg_in;
      if (accept && cfg_bad)            cfg_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) wgt_q[r][c] <= '0;
    end else if (wr) begin
      for (int c = 0; c < COLS; c++) wgt_q[w_row][c] <= w_data[c*DATA_W +: DATA_W];
    end
  end

  // Row r sees its element r cycles after row 0, matching the psum wavefront.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [DATA_W-1:0] sk_q [r+1];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= r; k++) sk_q[k] <= '0;
      end else begin
        sk_q[0] <= inputs[r*DATA_W +: DATA_W];
        for (int k = 1; k <= r; k++) sk_q[k] <= sk_q[k-1];
      end
    end
    assign x_row[r] = sk_q[r];

    for (genvar c = 0; c < COLS; c++) begin : g_col
      fusion_unit #(.DATA_W(DATA_W), .PSUM_W(PSUM_W)) u_fu (
        .a_i        (x_row[r]),
        .b_i        (wgt_q[r][c]),
        .a_width_i  (cfg_q.in_w),
        .b_width_i  (cfg_q.wt_w),
        .a_signed_i (cfg_q.s_in),
        .b_signed_i (cfg_q.s_wt),
        .prod_o     (prod[r][c])
      );
    end
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        psum_d[r][c] = prod[r][c];
        if (r > 0) psum_d[r][c] = prod[r][c] + psum_q[(r > 0) ? r - 1 : 0][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) psum_q[r][c] <= '0;
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      psums_q     <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) psum_q[r][c] <= psum_d[r][c];
      vld_q       <= {vld_q[ROWS-1:0], accept};
      out_valid_q <= vld_q[ROWS];
      if (vld_q[ROWS]) begin
        for (int c = 0; c < COLS; c++) psums_q[c*PSUM_W +: PSUM_W] <= psum_q[ROWS-1][c];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign psums     = psums_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_fusion_systolic_array.sv
// Directed bench for fusion_systolic_array with a golden-model scoreboard that
// checks every psum vector and its arrival cycle.
module tb_fusion_systolic_array;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int DW   = 8;
  localparam int PW   = 32;
  localparam int VW   = ROWS * DW;
  localparam int WW   = COLS * DW;
  localparam int OW   = COLS * PW;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      in_width, weight_width;
  logic            s_in, s_weight;
  logic            w_valid, w_ready;
  logic [2:0]      w_row;
  logic [WW-1:0]   w_data;
  logic            in_valid, in_ready;
  logic [VW-1:0]   inputs;
  logic            out_valid, busy, cfg_err;
  logic [OW-1:0]   psums;

  fusion_systolic_array #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .PSUM_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_width     (in_width),
    .weight_width (weight_width),
    .s_in         (s_in),
    .s_weight     (s_weight),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_row        (w_row),
    .w_data       (w_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .inputs       (inputs),
    .out_valid    (out_valid),
    .psums        (psums),
    .busy         (busy),
    .cfg_err      (cfg_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  // ---------------- scoreboard ----------------
  int            total = 0;
  int            bad   = 0;
  logic [OW-1:0] exp_q[$];
  int            exp_t_q[$];
  logic [DW-1:0] wm [ROWS][COLS];

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int legal_w(input logic [3:0] w);
    return (w == 4'd1 || w == 4'd2 || w == 4'd4 || w == 4'd8) ? int'(w) : 8;
  endfunction

  function automatic longint opv(input logic [DW-1:0] x, input int w, input bit s);
    longint m, v;
    m = longint'(1) << w;
    v = longint'(x) & (m - 1);
    if (s && v[w-1]) v = v - m;
    return v;
  endfunction

  function automatic logic [OW-1:0] golden(input logic [VW-1:0] v);
    logic [OW-1:0] g;
    int iw, ww;
    iw = legal_w(in_width);
    ww = legal_w(weight_width);
    g  = '0;
    for (int c = 0; c < COLS; c++) begin
      longint acc;
      acc = 0;
      for (int r = 0; r < ROWS; r++)
        acc += opv(v[r*DW +: DW], iw, s_in) * opv(wm[r][c], ww, s_weight);
      g[c*PW +: PW] = acc[PW-1:0];
    end
    return g;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  always @(negedge clk) begin : monitor
    logic [OW-1:0] e;
    int            t;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        check("psums", psums, e);
        check("latency_cycle", cyc, t);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [VW-1:0] v, output int stalls, output logic busy_at);
    bit done;
    done    = 0;
    stalls  = 0;
    busy_at = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      w_valid  = 1'b0;
      in_valid = 1'b1;
      inputs   = v;
      #1;
      if (in_ready) begin
        exp_q.push_back(golden(v));
        exp_t_q.push_back(cyc + ROWS + 2);
        busy_at = busy;
        done    = 1;
      end else begin
        stalls++;
      end
    end
    if (!done) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
  endtask

  task automatic load_row(input int r, input logic [WW-1:0] d, output int waits);
    bit done;
    done  = 0;
    waits = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      w_valid  = 1'b1;
      w_row    = 3'(r);
      w_data   = d;
      #1;
      if (w_ready) begin
        for (int c = 0; c < COLS; c++) wm[r][c] = d[c*DW +: DW];
        done = 1;
      end else begin
        waits++;
      end
    end
    if (!done) check("load_timeout", 0, 1);
    @(posedge clk);
    #1;
    w_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int            st, st_sum, wt, n_ov;
    logic          b_at;
    logic [VW-1:0] v;
    logic [WW-1:0] d;
    logic [OW-1:0] e;

    rst = 1'b1; in_width = 4'd8; weight_width = 4'd8; s_in = 1'b0; s_weight = 1'b0;
    w_valid = 1'b0; w_row = '0; w_data = '0; in_valid = 1'b0; inputs = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) wm[r][c] = '0;

    repeat (3) @(negedge clk);
    check("in_ready_in_rst", in_ready, 0);
    check("w_ready_in_rst", w_ready, 0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready, 1);
    check("w_ready_after_rst", w_ready, 1);
    check("busy_reset", busy, 0);
    check("out_valid_reset", out_valid, 0);
    check("psums_reset", psums, 0);
    check("cfg_err_reset", cfg_err, 0);

    // identity weights, inputs 1..8
    for (int r = 0; r < ROWS; r++) begin
      d = '0;
      d[r*DW +: DW] = 8'd1;
      load_row(r, d, wt);
    end
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = 8'(r + 1);
    send(v, st, b_at);
    idle_in();
    wait_drain("identity_drain");
    for (int c = 0; c < COLS; c++) e[c*PW +: PW] = 32'(c + 1);
    check("identity_psums", psums, e);
    repeat (3) @(negedge clk);
    check("out_valid_single_pulse", out_valid, 0);
    check("psums_hold", psums, e);

    // all weights -1 (signed), inputs +1 (signed)
    for (int r = 0; r < ROWS; r++) load_row(r, {COLS{8'hFF}}, wt);
    s_in = 1'b1; s_weight = 1'b1;
    send({ROWS{8'h01}}, st, b_at);
    idle_in();
    wait_drain("signed_drain");
    check("signed_psums", psums, {COLS{32'hFFFF_FFF8}});

    // random weights, 20 back-to-back random vectors
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) d[c*DW +: DW] = 8'($urandom_range(0, 255));
      load_row(r, d, wt);
    end
    s_in = 1'($urandom_range(0, 1)); s_weight = 1'($urandom_range(0, 1));
    st_sum = 0;
    for (int i = 0; i < 20; i++) begin
      send(rand_vec(), st, b_at);
      st_sum += st;
    end
    idle_in();
    wait_drain("stream_drain");
    check("stream_no_stalls", st_sum, 0);

    // weight write while vectors are in flight is held off until idle
    send(rand_vec(), st, b_at);
    send(rand_vec(), st, b_at);
    for (int c = 0; c < COLS; c++) d[c*DW +: DW] = 8'($urandom_range(0, 255));
    load_row(3, d, wt);
    check("wr_blocked_while_busy", (wt > 0), 1);
    check("busy_after_wr", busy, 0);
    send(rand_vec(), st, b_at);
    idle_in();
    wait_drain("post_wr_drain");

    // simultaneous weight write and vector in IDLE: weight first
    v = rand_vec();
    for (int c = 0; c < COLS; c++) d[c*DW +: DW] = 8'($urandom_range(0, 255));
    @(negedge clk);
    in_valid = 1'b1; inputs = v; w_valid = 1'b1; w_row = 3'd0; w_data = d;
    #1;
    check("simul_in_ready", in_ready, 0);
    check("simul_w_ready", w_ready, 1);
    for (int c = 0; c < COLS; c++) wm[0][c] = d[c*DW +: DW];
    @(negedge clk);
    w_valid = 1'b0;
    #1;
    check("simul_in_ready_next", in_ready, 1);
    if (in_ready) begin
      exp_q.push_back(golden(v));
      exp_t_q.push_back(cyc + ROWS + 2);
    end
    @(posedge clk);
    #1;
    idle_in();
    wait_drain("simul_drain");

    // precision change mid-stream stalls until the pipeline drains
    s_in = 1'b0; s_weight = 1'b0;
    for (int i = 0; i < 3; i++) send(rand_vec(), st, b_at);
    in_width = 4'd4;
    v = rand_vec();
    v[DW-1:0] = 8'h1F;
    send(v, st, b_at);
    check("width_change_stalled", (st > 0), 1);
    check("width_change_busy_at_accept", b_at, 0);
    idle_in();
    wait_drain("width4_drain");
    check("cfg_err_legal_widths", cfg_err, 0);

    // illegal width behaves as 8 and raises a sticky flag
    in_width = 4'd3;
    send(rand_vec(), st, b_at);
    idle_in();
    wait_drain("width3_drain");
    check("cfg_err_set", cfg_err, 1);
    in_width = 4'd8;
    send(rand_vec(), st, b_at);
    idle_in();
    wait_drain("width8_drain");
    check("cfg_err_sticky", cfg_err, 1);

    // reset with 5 vectors in flight
    for (int i = 0; i < 5; i++) send(rand_vec(), st, b_at);
    idle_in();
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    exp_t_q.delete();
    @(negedge clk);
    check("in_ready_mid_rst", in_ready, 0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst2", in_ready, 1);
    check("psums_after_rst2", psums, 0);
    check("cfg_err_after_rst2", cfg_err, 0);
    check("busy_after_rst2", busy, 0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) wm[r][c] = '0;
    n_ov = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) n_ov++;
    end
    check("no_out_valid_after_rst", n_ov, 0);
    send(rand_vec(), st, b_at);
    idle_in();
    wait_drain("zero_weights_drain");
    check("zero_weights_psums", psums, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fusion_systolic_array.md
FUSION_SYSTOLIC_ARRAY -- requirements
Module: fusion_systolic_array

Interface
REQ-001 Parameters SHALL be: ROWS, default 8, array rows (reduction depth); COLS, default 8, array columns (output channels); DATA_W, default 8, input/weight element width; PSUM_W, default 32, partial-sum width.
REQ-002 Ports SHALL be: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-003 Config ports SHALL be: in_width  in  4  input precision; weight_width  in  4  weight precision; s_in  in  1  inputs signed; s_weight  in  1  weights signed.
REQ-004 Weight-load ports SHALL be: w_valid  in  1  weight row write request; w_ready  out  1  write accepted; w_row  in  clog2(ROWS)  target row; w_data  in  COLS*DATA_W  one row of weights, column 0 in LSBs.
REQ-005 Input ports SHALL be: in_valid  in  1  input vector present; in_ready  out  1  vector accepted; inputs  in  ROWS*DATA_W  one element per row, row 0 in LSBs.
REQ-006 Output ports SHALL be: out_valid  out  1  psums valid; psums  out  COLS*PSUM_W  one sum per column, column 0 in LSBs; busy  out  1  pipeline non-empty; cfg_err  out  1  sticky illegal-precision flag.

Function
REQ-007 Weights SHALL be stationary: a w_valid&&w_ready cycle writes w_data into weight row w_row at the clock edge.
REQ-008 Each accepted input vector SHALL produce psums[c] = sum over r of inputs[r]*weight[r][c], products and sum sign-extended per s_in/s_weight, wrapped modulo 2^PSUM_W.
REQ-009 Precision SHALL be applied by the existing fusion_unit; only bits [width-1:0] of each operand are significant.
REQ-010 Legal widths SHALL be 1, 2, 4, 8; any other value SHALL be treated as 8 and SHALL set cfg_err, which stays set until rst.
REQ-011 Psum SHALL be registered between every row; the block SHALL skew row r's input by r cycles internally, so callers present whole vectors.
REQ-012 Latency SHALL be exactly ROWS+1 cycles from the in_valid&&in_ready edge to out_valid high with the matching psums (one final output register).
REQ-013 Throughput SHALL be one vector per cycle with in_valid held; results SHALL emerge in acceptance order; no output backpressure exists.
REQ-014 out_valid SHALL be high for exactly one cycle per accepted vector; psums SHALL hold last value while out_valid is low.
REQ-015 Config (in_width, weight_width, s_in, s_weight) SHALL be latched on the first accepted vector while idle and SHALL travel with each vector; a config differing from the latched one while busy SHALL deassert in_ready until the pipeline drains.
REQ-016 State machine SHALL have IDLE (empty), RUN (vectors in flight), DRAIN (config change or weight write pending, no new accepts); RUN->DRAIN on pending change, DRAIN->IDLE when busy falls, IDLE->RUN on accept.
REQ-017 w_ready SHALL be high only in IDLE; a w_valid in RUN SHALL force DRAIN and be accepted once IDLE.
REQ-018 Simultaneous w_valid and in_valid in IDLE SHALL grant the weight write first; in_ready low that cycle.
REQ-019 busy SHALL be high while any accepted vector has not yet produced out_valid.

Reset
REQ-020 On rst: out_valid=0, psums=0, busy=0, cfg_err=0, state=IDLE, all skew/psum pipeline registers and in-flight valids cleared; weights SHALL reset to 0.
REQ-021 rst mid-operation SHALL discard all in-flight vectors; no out_valid SHALL follow for them.
REQ-022 in_ready and w_ready SHALL be 0 during rst and 1 in the first cycle after rst deasserts.

Structure
REQ-023 Shared package bf_pkg SHALL hold DATA_W/PSUM_W defaults, legal-width constants, the state enum, and the width-legalising function.
REQ-024 One sub-module SHALL be instantiated ROWS*COLS times: fusion_unit (existing, combinational), with pipeline registers in this block.

Verification
REQ-025 Load identity weights (ROWS=COLS=8, width 8, unsigned), inputs 1..8 -> after 9 cycles psums = 1..8, out_valid one cycle.
REQ-026 All weights 0xFF signed, inputs 0x01 signed, width 8 -> psums[c] = -8 (0xFFFFFFF8) each column.
REQ-027 Stream 20 back-to-back random vectors -> 20 consecutive out_valid pulses, values match golden model, order preserved.
REQ-028 Change in_width 8->4 mid-stream -> in_ready low until busy falls, then new vectors computed with 4-bit operands (e.g., input 0x1F treated as 0xF).
REQ-029 in_width=3 -> cfg_err=1, result equals width-8 result; cfg_err held until rst.
REQ-030 Assert rst with 5 vectors in flight -> no out_valid afterwards, psums=0, in_ready=1 the cycle after rst falls.
